// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - sequencer for the 2-way write-through cache datapath and its RAM bus
module cache_controller #(
    parameter int LINES = 8,
    parameter int WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_ready_o,
    output logic        c_write_o,
    output logic        c_force_write_o,
    output logic        c_ram_buf_write_o,
    output logic        c_read_ram_buf_o,
    output logic        c_pos_o,
    output logic [31:0] c_address_o,
    output logic [31:0] c_data_in_o,
    input  logic        c_hit_i,
    input  logic        c_full_i,
    input  logic        c_empty_i,
    input  logic [31:0] c_data_i,
    input  logic [31:0] c_addr_to_mem_i,
    input  logic [31:0] c_data_to_mem_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    localparam int LINE_W = $clog2(LINES);
    localparam int WORD_W = $clog2(WORDS);
    localparam int OFF_W  = WORD_W + 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAIN  = 2'd1,
        S_REFILL = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   cnt_q, cnt_d;
    logic [LINES-1:0]    victim_q, victim_d;
    // Line base latched at miss time so a mid-burst CPU address change cannot corrupt the refill.
    logic [31-OFF_W:0]   base_q, base_d;
    logic [LINE_W-1:0]   line;
    logic [31:0]         refill_addr;

    assign line        = base_q[LINE_W-1:0];
    assign refill_addr = {base_q, cnt_q, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            victim_q <= '0;
            base_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            victim_q <= victim_d;
            base_q   <= base_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        victim_d          = victim_q;
        base_d            = base_q;
        cpu_rdata_o       = '0;
        cpu_ready_o       = 1'b0;
        c_write_o         = 1'b0;
        c_force_write_o   = 1'b0;
        c_ram_buf_write_o = 1'b0;
        c_read_ram_buf_o  = 1'b0;
        c_pos_o           = 1'b0;
        c_address_o       = cpu_addr_i;
        c_data_in_o       = cpu_wdata_i;
        mem_req_o         = 1'b0;
        mem_we_o          = 1'b0;
        mem_addr_o        = '0;
        mem_wdata_o       = '0;

        if (!rst) begin
            unique case (state_q)
                S_IDLE: begin
                    if (cpu_req_i) begin
                        if (!cpu_we_i) begin
                            if (c_hit_i) begin
                                cpu_ready_o = 1'b1;
                                cpu_rdata_o = c_data_i;
                            end else if (c_empty_i) begin
                                state_d = S_REFILL;
                                base_d  = cpu_addr_i[31:OFF_W];
                                cnt_d   = '0;
                            end else begin
                                // RAM must be current before the line is fetched.
                                state_d = S_DRAIN;
                            end
                        end else if (!c_full_i) begin
                            cpu_ready_o       = 1'b1;
                            c_write_o         = 1'b1;
                            c_ram_buf_write_o = 1'b1;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end else if (!c_empty_i) begin
                        state_d = S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_addr_o  = c_addr_to_mem_i;
                    mem_wdata_o = c_data_to_mem_i;
                    if (mem_ack_i) begin
                        c_read_ram_buf_o = 1'b1;
                        state_d          = S_IDLE;
                    end
                end

                S_REFILL: begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = refill_addr;
                    if (mem_ack_i) begin
                        c_write_o       = 1'b1;
                        c_force_write_o = 1'b1;
                        c_pos_o         = victim_q[line];
                        c_address_o     = refill_addr;
                        c_data_in_o     = mem_rdata_i;
                        cnt_d           = cnt_q + 1'b1;
                        if (cnt_q == WORD_W'(WORDS - 1)) begin
                            victim_d[line] = ~victim_q[line];
                            state_d        = S_IDLE;
                        end
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule
